nodf_module_status_tracker: RTL and testbench

- Synthesizable status/profiling tracker for one non-dataflow HLS module.
- Samples the module's ap_start/ap_ready/ap_done/ap_continue handshake plus a global finish strobe.
- Maintains a transaction state machine and cycle/latency/stall statistics, frozen at finish for readout.
- One instance per monitored module, sitting beside the DUT in the simulation/debug top.

---
 rtl/nodf_module_status_tracker.sv | 183 ++++++++++++++++++
 tb/tb_nodf_module_status_tracker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/nodf_module_status_tracker.sv
// Handshake status and latency profiler for one non-dataflow HLS module.
// All statistics are registered and stop updating once finish has been sampled.
module nodf_module_status_tracker #(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ap_start,
   input  logic             ap_ready,
   input  logic             ap_done,
   input  logic             ap_continue,
   input  logic             finish,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] start_cnt,
   output logic [CNT_W-1:0] done_cnt,
   output logic [CNT_W-1:0] ready_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] last_latency,
   output logic [CNT_W-1:0] min_latency,
   output logic [CNT_W-1:0] max_latency,
   output logic             frozen,
   output logic             saturated,
   output logic             spurious_done
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      BUSY      = 2'd1,
      WAIT_CONT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] ALL_ONES = '1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + ONE;
   endfunction

   // Unknown (X/Z) inputs are treated as deasserted.
   logic start_i, ready_i, done_i, cont_i, finish_i;
   assign start_i  = (ap_start === 1'b1);
   assign ready_i  = (ap_ready === 1'b1);
   assign done_i   = (ap_done === 1'b1);
   assign cont_i   = (ap_continue === 1'b1);
   assign finish_i = (finish === 1'b1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0] start_cnt_q, start_cnt_d;
   logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
   logic [CNT_W-1:0] ready_cnt_q, ready_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] run_q, run_d;
   logic [CNT_W-1:0] last_lat_q, last_lat_d;
   logic [CNT_W-1:0] min_lat_q, min_lat_d;
   logic [CNT_W-1:0] max_lat_q, max_lat_d;
   logic             frozen_q, frozen_d;
   logic             saturated_q, saturated_d;
   logic             spurious_q, spurious_d;
   logic             complete;
   logic [CNT_W-1:0] lat;

   always_comb begin
      state_d     = state_q;
      cycle_cnt_d = cycle_cnt_q;
      start_cnt_d = start_cnt_q;
      done_cnt_d  = done_cnt_q;
      ready_cnt_d = ready_cnt_q;
      stall_cnt_d = stall_cnt_q;
      run_d       = run_q;
      last_lat_d  = last_lat_q;
      min_lat_d   = min_lat_q;
      max_lat_d   = max_lat_q;
      frozen_d    = frozen_q;
      saturated_d = saturated_q;
      spurious_d  = spurious_q;
      complete    = 1'b0;
      lat         = '0;

      // The edge that samples finish only sets frozen; nothing else moves afterwards.
      if (!frozen_q) begin
         if (finish_i) begin
            frozen_d = 1'b1;
         end else begin
            cycle_cnt_d = sat_inc(cycle_cnt_q);
            if (ready_i)
               ready_cnt_d = sat_inc(ready_cnt_q);
            if (done_i && !cont_i)
               stall_cnt_d = sat_inc(stall_cnt_q);

            case (state_q)
               IDLE: begin
                  if (start_i) begin
                     start_cnt_d = sat_inc(start_cnt_q);
                     run_d       = ONE;
                     if (done_i && cont_i) begin
                        complete = 1'b1;
                        lat      = ONE;
                        state_d  = IDLE;
                     end else if (done_i) begin
                        state_d = WAIT_CONT;
                     end else begin
                        state_d = BUSY;
                     end
                  end else if (done_i) begin
                     spurious_d = 1'b1;
                  end
               end
               BUSY, WAIT_CONT: begin
                  run_d = sat_inc(run_q);
                  if (done_i && cont_i) begin
                     complete = 1'b1;
                     lat      = sat_inc(run_q);
                     state_d  = IDLE;
                  end else if (done_i && state_q == BUSY) begin
                     state_d = WAIT_CONT;
                  end
               end
               default: state_d = IDLE;
            endcase

            if (complete) begin
               done_cnt_d = sat_inc(done_cnt_q);
               last_lat_d = lat;
               if (lat < min_lat_q)
                  min_lat_d = lat;
               if (lat > max_lat_q)
                  max_lat_d = lat;
            end

            saturated_d = saturated_q | (&cycle_cnt_d) | (&start_cnt_d) |
                          (&done_cnt_d) | (&ready_cnt_d) | (&stall_cnt_d) | (&run_d);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cycle_cnt_q <= '0;
         start_cnt_q <= '0;
         done_cnt_q  <= '0;
         ready_cnt_q <= '0;
         stall_cnt_q <= '0;
         run_q       <= '0;
         last_lat_q  <= '0;
         min_lat_q   <= ALL_ONES;
         max_lat_q   <= '0;
         frozen_q    <= 1'b0;
         saturated_q <= 1'b0;
         spurious_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cycle_cnt_q <= cycle_cnt_d;
         start_cnt_q <= start_cnt_d;
         done_cnt_q  <= done_cnt_d;
         ready_cnt_q <= ready_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         run_q       <= run_d;
         last_lat_q  <= last_lat_d;
         min_lat_q   <= min_lat_d;
         max_lat_q   <= max_lat_d;
         frozen_q    <= frozen_d;
         saturated_q <= saturated_d;
         spurious_q  <= spurious_d;
      end
   end

   assign state         = state_q;
   assign cycle_cnt     = cycle_cnt_q;
   assign start_cnt     = start_cnt_q;
   assign done_cnt      = done_cnt_q;
   assign ready_cnt     = ready_cnt_q;
   assign stall_cnt     = stall_cnt_q;
   assign last_latency  = last_lat_q;
   assign min_latency   = min_lat_q;
   assign max_latency   = max_lat_q;
   assign frozen        = frozen_q;
   assign saturated     = saturated_q;
   assign spurious_done = spurious_q;

endmodule

// File: tb/tb_nodf_module_status_tracker.sv
// Directed self-checking bench for nodf_module_status_tracker.
// A 32-bit instance covers function; a 4-bit instance covers saturation.
module tb_nodf_module_status_tracker;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic ap_start = 1'b0;
   logic ap_ready = 1'b0;
   logic ap_done = 1'b0;
   logic ap_continue = 1'b1;
   logic finish = 1'b0;

   logic [1:0]  state;
   logic [31:0] cycle_cnt, start_cnt, done_cnt, ready_cnt, stall_cnt;
   logic [31:0] last_latency, min_latency, max_latency;
   logic        frozen, saturated, spurious_done;

   logic [1:0]  satState;
   logic [3:0]  satCycle, satStart, satDone, satReady, satStall;
   logic [3:0]  satLast, satMin, satMax;
   logic        satFrozen, satSaturated, satSpurious;

   int checkCount = 0;
   int errorCount = 0;

   always #5 clock = ~clock;

   nodf_module_status_tracker #(.CNT_W(32)) dut (
      .clock(clock), .reset(reset),
      .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
      .ap_continue(ap_continue), .finish(finish),
      .state(state), .cycle_cnt(cycle_cnt), .start_cnt(start_cnt),
      .done_cnt(done_cnt), .ready_cnt(ready_cnt), .stall_cnt(stall_cnt),
      .last_latency(last_latency), .min_latency(min_latency),
      .max_latency(max_latency), .frozen(frozen), .saturated(saturated),
      .spurious_done(spurious_done)
   );

   nodf_module_status_tracker #(.CNT_W(4)) dutSat (
      .clock(clock), .reset(reset),
      .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
      .ap_continue(ap_continue), .finish(finish),
      .state(satState), .cycle_cnt(satCycle), .start_cnt(satStart),
      .done_cnt(satDone), .ready_cnt(satReady), .stall_cnt(satStall),
      .last_latency(satLast), .min_latency(satMin),
      .max_latency(satMax), .frozen(satFrozen), .saturated(satSaturated),
      .spurious_done(satSpurious)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, clock it, and settle just after the edge.
   task automatic applyStimulus(input logic st, input logic rd, input logic dn,
                                input logic ct, input logic fn);
      ap_start    = st;
      ap_ready    = rd;
      ap_done     = dn;
      ap_continue = ct;
      finish      = fn;
      @(posedge clock);
      #1;
   endtask

   task automatic doReset();
      reset       = 1'b0;
      ap_start    = 1'b0;
      ap_ready    = 1'b0;
      ap_done     = 1'b0;
      ap_continue = 1'b1;
      finish      = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      $display("[TB] starting");

      // Reset state
      doReset();
      checkOutput("rst_state", {30'd0, state}, 32'd0);
      checkOutput("rst_cycle", cycle_cnt, 32'd0);
      checkOutput("rst_start", start_cnt, 32'd0);
      checkOutput("rst_min", min_latency, 32'hFFFF_FFFF);
      checkOutput("rst_max", max_latency, 32'd0);
      checkOutput("rst_flags", {29'd0, frozen, saturated, spurious_done}, 32'd0);

      // Basic transaction: start cycles 2..5, ready at 5, done at 7
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(1, 0, 0, 1, 0);
      checkOutput("basic_busy", {30'd0, state}, 32'd1);
      applyStimulus(1, 0, 0, 1, 0);
      applyStimulus(1, 0, 0, 1, 0);
      applyStimulus(1, 1, 0, 1, 0);
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 1, 1, 0);
      checkOutput("basic_start", start_cnt, 32'd1);
      checkOutput("basic_done", done_cnt, 32'd1);
      checkOutput("basic_last", last_latency, 32'd6);
      checkOutput("basic_min", min_latency, 32'd6);
      checkOutput("basic_max", max_latency, 32'd6);
      checkOutput("basic_ready", ready_cnt, 32'd1);
      checkOutput("basic_state", {30'd0, state}, 32'd0);
      checkOutput("basic_cycle", cycle_cnt, 32'd7);
      checkOutput("basic_spur", {31'd0, spurious_done}, 32'd0);

      // Continue stall: begin at 2, done 5..8, continue only at 8
      doReset();
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(1, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("stall_wait5", {30'd0, state}, 32'd2);
      applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("stall_wait7", {30'd0, state}, 32'd2);
      applyStimulus(0, 0, 1, 1, 0);
      checkOutput("stall_cnt", stall_cnt, 32'd3);
      checkOutput("stall_last", last_latency, 32'd7);
      checkOutput("stall_state", {30'd0, state}, 32'd0);
      checkOutput("stall_done", done_cnt, 32'd1);

      // Same-cycle begin and complete
      doReset();
      applyStimulus(1, 0, 1, 1, 0);
      checkOutput("same_start", start_cnt, 32'd1);
      checkOutput("same_done", done_cnt, 32'd1);
      checkOutput("same_last", last_latency, 32'd1);
      checkOutput("same_state", {30'd0, state}, 32'd0);
      checkOutput("same_spur", {31'd0, spurious_done}, 32'd0);

      // Back-to-back: latency 4 then 9, start held through first complete
      doReset();
      applyStimulus(1, 0, 0, 1, 0);
      applyStimulus(1, 0, 0, 1, 0);
      applyStimulus(1, 0, 0, 1, 0);
      applyStimulus(1, 0, 1, 1, 0);
      checkOutput("b2b_idle", {30'd0, state}, 32'd0);
      checkOutput("b2b_start1", start_cnt, 32'd1);
      applyStimulus(1, 0, 0, 1, 0);
      for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 1, 1, 0);
      checkOutput("b2b_start", start_cnt, 32'd2);
      checkOutput("b2b_done", done_cnt, 32'd2);
      checkOutput("b2b_min", min_latency, 32'd4);
      checkOutput("b2b_max", max_latency, 32'd9);
      checkOutput("b2b_last", last_latency, 32'd9);

      // Ready-only pulses and a stray done
      doReset();
      applyStimulus(0, 1, 0, 1, 0);
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 1, 0, 1, 0);
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 1, 0, 1, 0);
      checkOutput("rdy_spur0", {31'd0, spurious_done}, 32'd0);
      applyStimulus(0, 0, 1, 1, 0);
      checkOutput("rdy_ready", ready_cnt, 32'd3);
      checkOutput("rdy_start", start_cnt, 32'd0);
      checkOutput("rdy_done", done_cnt, 32'd0);
      checkOutput("rdy_spur", {31'd0, spurious_done}, 32'd1);
      checkOutput("rdy_state", {30'd0, state}, 32'd0);

      // Finish mid-transaction freezes everything; async reset clears it
      doReset();
      applyStimulus(1, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("fin_frozen", {31'd0, frozen}, 32'd1);
      checkOutput("fin_cycle0", cycle_cnt, 32'd3);
      for (int i = 0; i < 20; i++) applyStimulus(1, 1, 1, 0, 0);
      checkOutput("fin_cycle", cycle_cnt, 32'd3);
      checkOutput("fin_start", start_cnt, 32'd1);
      checkOutput("fin_ready", ready_cnt, 32'd0);
      checkOutput("fin_stall", stall_cnt, 32'd0);
      checkOutput("fin_state", {30'd0, state}, 32'd1);
      checkOutput("fin_hold", {31'd0, frozen}, 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("arst_frozen", {31'd0, frozen}, 32'd0);
      checkOutput("arst_cycle", cycle_cnt, 32'd0);
      checkOutput("arst_min", min_latency, 32'hFFFF_FFFF);
      checkOutput("arst_state", {30'd0, state}, 32'd0);
      checkOutput("arst_start", start_cnt, 32'd0);

      // Saturation on the 4-bit instance: 16 transactions of latency 2
      doReset();
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1, 0, 0, 1, 0);
         applyStimulus(0, 0, 1, 1, 0);
      end
      checkOutput("sat_start", {28'd0, satStart}, 32'd15);
      checkOutput("sat_done", {28'd0, satDone}, 32'd15);
      checkOutput("sat_cycle", {28'd0, satCycle}, 32'd15);
      checkOutput("sat_flag", {31'd0, satSaturated}, 32'd1);
      checkOutput("sat_last", {28'd0, satLast}, 32'd2);
      checkOutput("wide_start", start_cnt, 32'd16);
      checkOutput("wide_flag", {31'd0, saturated}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
